ldr_str_unit: RTL and testbench
===============================

Name: ldr_str_unit

Overview:
Memory-access stage that executes LDR/STR/LDRB/STRB transactions between the datapath and the data RAM. It sits directly upstream of the register file's load write port and drives w_data_ldr / w_addr_ldr / w_en_ldr. Store data comes from the register file's str_data read port, and the effective address comes from the datapath ALU result. It runs one transaction at a time through a small FSM, with a ready handshake on the RAM side and a timeout.

Parameters:
ADDR_W, 11, byte-address width of the data memory (word address = ADDR_W-2 bits)
TIMEOUT, 15, maximum wait cycles for mem_ready before the transaction is aborted (1..255)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
start  input  1  one-cycle request pulse; sampled only in IDLE
is_load  input  1  1 = load, 0 = store
is_byte  input  1  1 = byte access, 0 = word access
addr  input  ADDR_W  effective byte address
str_data  input  32  store data from the register file's str port
rd_addr  input  4  load destination register
mem_addr  output  ADDR_W-2  word address to RAM
mem_wdata  output  32  write data
mem_be  output  4  byte-lane enables
mem_ren  output  1  read request
mem_wen  output  1  write request
mem_rdata  input  32  read data, valid when mem_ready=1
mem_ready  input  1  RAM accepts/completes the request this cycle
w_data_ldr  output  32  load result to the register file
w_addr_ldr  output  4  load destination to the register file
w_en_ldr  output  1  one-cycle write strobe to the register file
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle completion pulse
err  output  1  one-cycle error pulse, coincident with done

Behaviour:
- Reset: one clk edge with rst=1.
  - State goes to IDLE and the wait counter clears.
  - All outputs go to 0: mem_*, w_*, busy, done, err.
  - Reset mid-transaction drops the request on the next edge. No register-file write and no done pulse follow.
- States: IDLE, REQ, WB, DONE, ERR.
- IDLE, start=1:
  - Latch addr, str_data, rd_addr, is_load and is_byte. Inputs may change afterwards.
  - Misaligned word access (is_byte=0 and addr[1:0]!=0) goes to ERR with no RAM access.
  - Otherwise go to REQ.
  - start outside IDLE is ignored.
- REQ:
  - mem_ren = is_load and mem_wen = !is_load. mem_addr = latched addr[ADDR_W-1:2].
  - Word access: mem_be=4'b1111, mem_wdata = str_data.
  - Byte access: mem_be = one-hot at lane addr[1:0] (little-endian), mem_wdata = str_data[7:0] replicated in all four lanes.
  - Request signals are held stable until mem_ready=1 is sampled.
  - On mem_ready=1: a store goes to DONE; a load captures mem_rdata and goes to WB.
  - Wait counter increments each REQ cycle with mem_ready=0. When it reaches TIMEOUT, go to ERR and drop the request.
- WB:
  - w_en_ldr=1 for exactly one cycle, w_addr_ldr = latched rd_addr.
  - w_data_ldr = captured word, or the zero-extended byte at lane addr[1:0].
  - If rd_addr==4'd15, w_en_ldr stays 0: the register file does not write PC through this port, and PC loads go through dp_pc.
  - Next state DONE.
- DONE: done=1 for one cycle, then IDLE.
- ERR: done=1 and err=1 for one cycle, no register write, then IDLE.
- Latency, counted from start at cycle 0 with mem_ready already high:
  - Store: REQ at 1, done at 2.
  - Load: REQ at 1, w_en_ldr at 2, done at 3.
  - Each mem_ready=0 cycle adds one cycle.
- Back-to-back: a new start is accepted in the cycle after done (IDLE), so the minimum issue interval is 3 cycles for a store and 4 for a load.
- Output timing: w_data_ldr / w_addr_ldr hold their last values outside WB. mem_ren, mem_wen and mem_be are 0 outside REQ.
- Counter width: 8 bits, cleared on entry to REQ.

Test Plan:
- Aligned word load: addr=0x010, rd=3, RAM returns 0xDEADBEEF with ready on the first cycle -> mem_addr=0x004 and mem_ren in cycle 1; w_en_ldr=1, w_addr_ldr=3, w_data_ldr=0xDEADBEEF in cycle 2; done in cycle 3.
- Byte store: addr=0x013, str_data=0x123456AB, ready delayed 2 cycles -> mem_be=4'b1000 and mem_wdata=0xABABABAB held for 3 cycles; done 1 cycle after ready; w_en_ldr never asserted.
- Byte load: addr=0x006, mem_rdata=0x11C23344 -> w_data_ldr=0x000000C2.
- Misaligned word store: addr=0x002 -> ERR next cycle with done=err=1; mem_wen never asserted.
- Timeout: load with mem_ready held 0 -> mem_ren high for TIMEOUT=15 cycles, then done=err=1 with no write. Load with rd=15 -> done, w_en_ldr=0.
- Reset mid-wait: rst=1 in the 2nd REQ cycle -> all outputs 0 and busy=0 after that edge; a new start after reset completes normally.

Source files
------------

// File: rtl/ldr_str_unit.sv
// Memory-access stage: runs one LDR/STR/LDRB/STRB at a time against the data RAM
// and returns load results to the register file's load write port.
module ldr_str_unit #(
  parameter int ADDR_W  = 11,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_load,
  input  logic              is_byte,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       str_data,
  input  logic [3:0]        rd_addr,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  output logic              mem_ren,
  output logic              mem_wen,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [31:0]       w_data_ldr,
  output logic [3:0]        w_addr_ldr,
  output logic              w_en_ldr,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {IDLE, REQ, WB, DONE, ERR} state_t;

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;
  logic [3:0]        rd_q;
  logic              load_q;
  logic              byte_q;
  logic [7:0]        wait_cnt;
  logic [31:0]       w_data_q;
  logic [3:0]        w_addr_q;
  logic [7:0]        rd_byte;
  logic [31:0]       load_val;
  logic              misaligned;

  assign misaligned = !is_byte && (addr[1:0] != 2'b00);

  always_comb begin
    rd_byte = mem_rdata[7:0];
    case (addr_q[1:0])
      2'd0: rd_byte = mem_rdata[7:0];
      2'd1: rd_byte = mem_rdata[15:8];
      2'd2: rd_byte = mem_rdata[23:16];
      2'd3: rd_byte = mem_rdata[31:24];
      default: rd_byte = mem_rdata[7:0];
    endcase
    load_val = byte_q ? {24'd0, rd_byte} : mem_rdata;
  end

  // The load result is registered on the ready edge so it stays put after WB.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      addr_q   <= '0;
      data_q   <= '0;
      rd_q     <= '0;
      load_q   <= 1'b0;
      byte_q   <= 1'b0;
      wait_cnt <= '0;
      w_data_q <= '0;
      w_addr_q <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            addr_q   <= addr;
            data_q   <= str_data;
            rd_q     <= rd_addr;
            load_q   <= is_load;
            byte_q   <= is_byte;
            wait_cnt <= '0;
          end
        end
        REQ: begin
          if (mem_ready) begin
            if (load_q) begin
              w_data_q <= load_val;
              w_addr_q <= rd_q;
            end
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    mem_ren   = 1'b0;
    mem_wen   = 1'b0;
    w_en_ldr  = 1'b0;
    busy      = (state != IDLE);
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = misaligned ? ERR : REQ;
      end
      REQ: begin
        mem_addr  = addr_q[ADDR_W-1:2];
        mem_ren   = load_q;
        mem_wen   = !load_q;
        mem_be    = byte_q ? (4'b0001 << addr_q[1:0]) : 4'b1111;
        mem_wdata = byte_q ? {4{data_q[7:0]}} : data_q;
        if (mem_ready)
          state_nxt = load_q ? WB : DONE;
        else if (wait_cnt + 8'd1 == TMO)
          state_nxt = ERR;
      end
      WB: begin
        // PC is never written through this port.
        w_en_ldr  = (rd_q != 4'd15);
        state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      ERR: begin
        done      = 1'b1;
        err       = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign w_data_ldr = w_data_q;
  assign w_addr_ldr = w_addr_q;

endmodule

// File: tb/tb_ldr_str_unit.sv
// Bench for ldr_str_unit: directed test-plan steps plus random transactions,
// each compared cycle by cycle against an outcome model of the transaction.
module tb_ldr_str_unit;

  localparam int ADDR_W  = 11;
  localparam int TIMEOUT = 15;

  logic              clk;
  logic              rst;
  logic              start;
  logic              is_load;
  logic              is_byte;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       str_data;
  logic [3:0]        rd_addr;
  logic [ADDR_W-3:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  logic              mem_ren;
  logic              mem_wen;
  logic [31:0]       mem_rdata;
  logic              mem_ready;
  logic [31:0]       w_data_ldr;
  logic [3:0]        w_addr_ldr;
  logic              w_en_ldr;
  logic              busy;
  logic              done;
  logic              err;

  int checks = 0;
  int errors = 0;
  logic [31:0] lastWData = '0;
  logic [3:0]  lastWAddr = '0;

  ldr_str_unit #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .is_load(is_load), .is_byte(is_byte),
    .addr(addr), .str_data(str_data), .rd_addr(rd_addr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .w_data_ldr(w_data_ldr), .w_addr_ldr(w_addr_ldr),
    .w_en_ldr(w_en_ldr), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, ":busy"},    32'(busy), 32'd0);
    checkOutput({tag, ":done"},    32'(done), 32'd0);
    checkOutput({tag, ":err"},     32'(err), 32'd0);
    checkOutput({tag, ":mem_ren"}, 32'(mem_ren), 32'd0);
    checkOutput({tag, ":mem_wen"}, 32'(mem_wen), 32'd0);
    checkOutput({tag, ":mem_be"},  32'(mem_be), 32'd0);
    checkOutput({tag, ":w_en"},    32'(w_en_ldr), 32'd0);
    checkOutput({tag, ":w_data"},  w_data_ldr, lastWData);
    checkOutput({tag, ":w_addr"},  32'(w_addr_ldr), 32'(lastWAddr));
  endtask

  // One complete transaction; 'delay' is the number of not-ready REQ cycles.
  task automatic applyStimulus(input string tag, input bit load, input bit byteAcc,
                               input logic [ADDR_W-1:0] a, input logic [31:0] d,
                               input logic [3:0] rd, input logic [31:0] rdata,
                               input int delay);
    int          lane;
    bit          misaligned, timeout, writeback;
    int          reqCycles;
    logic [31:0] expBe, expWdata, expLoad;

    lane       = int'(a) % 4;
    misaligned = !byteAcc && (lane != 0);
    timeout    = !misaligned && (delay >= TIMEOUT);
    reqCycles  = misaligned ? 0 : (timeout ? TIMEOUT : delay + 1);
    expBe      = byteAcc ? (32'd1 << lane) : 32'hF;
    expWdata   = byteAcc ? {4{d[7:0]}} : d;
    expLoad    = byteAcc ? ((rdata >> (8 * lane)) & 32'hFF) : rdata;
    writeback  = load && !misaligned && !timeout;

    checkIdle({tag, ":pre"});
    start = 1'b1; is_load = load; is_byte = byteAcc;
    addr = a; str_data = d; rd_addr = rd;
    mem_ready = 1'b0; mem_rdata = $urandom;
    @(negedge clk);
    start = 1'b0;
    is_load = 1'($urandom); is_byte = 1'($urandom);
    addr = ADDR_W'($urandom); str_data = $urandom; rd_addr = 4'($urandom);

    for (int i = 0; i < reqCycles; i++) begin
      checkOutput({tag, ":req_busy"},    32'(busy), 32'd1);
      checkOutput({tag, ":req_done"},    32'(done), 32'd0);
      checkOutput({tag, ":req_ren"},     32'(mem_ren), 32'(load));
      checkOutput({tag, ":req_wen"},     32'(mem_wen), 32'(!load));
      checkOutput({tag, ":req_addr"},    32'(mem_addr), 32'(a) >> 2);
      checkOutput({tag, ":req_be"},      32'(mem_be), expBe);
      if (!load) checkOutput({tag, ":req_wdata"}, mem_wdata, expWdata);
      checkOutput({tag, ":req_w_en"},    32'(w_en_ldr), 32'd0);
      start     = 1'($urandom);
      mem_ready = (i == delay);
      mem_rdata = (i == delay) ? rdata : $urandom;
      @(negedge clk);
    end
    start = 1'b0;
    mem_ready = 1'b0;

    if (writeback) begin
      lastWData = expLoad;
      lastWAddr = rd;
      checkOutput({tag, ":wb_w_en"},  32'(w_en_ldr), 32'(rd != 4'd15));
      checkOutput({tag, ":wb_w_addr"}, 32'(w_addr_ldr), 32'(rd));
      checkOutput({tag, ":wb_w_data"}, w_data_ldr, expLoad);
      checkOutput({tag, ":wb_done"},  32'(done), 32'd0);
      checkOutput({tag, ":wb_ren"},   32'(mem_ren), 32'd0);
      @(negedge clk);
    end

    checkOutput({tag, ":fin_done"}, 32'(done), 32'd1);
    checkOutput({tag, ":fin_err"},  32'(err), 32'(misaligned || timeout));
    checkOutput({tag, ":fin_busy"}, 32'(busy), 32'd1);
    checkOutput({tag, ":fin_w_en"}, 32'(w_en_ldr), 32'd0);
    checkOutput({tag, ":fin_ren"},  32'(mem_ren), 32'd0);
    checkOutput({tag, ":fin_wen"},  32'(mem_wen), 32'd0);
    @(negedge clk);
    checkIdle({tag, ":post"});
  endtask

  initial begin
    logic [ADDR_W-1:0] ra;
    bit                rb;
    int                rdly;

    rst = 1'b1; start = 1'b0; is_load = 1'b0; is_byte = 1'b0;
    addr = '0; str_data = '0; rd_addr = '0; mem_rdata = '0; mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkIdle("reset");
    checkOutput("reset:mem_addr",  32'(mem_addr), 32'd0);
    checkOutput("reset:mem_wdata", mem_wdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus("word_load",  1'b1, 1'b0, 11'h010, 32'h0, 4'd3, 32'hDEADBEEF, 0);
    applyStimulus("byte_store", 1'b0, 1'b1, 11'h013, 32'h123456AB, 4'd0, 32'h0, 2);
    applyStimulus("byte_load",  1'b1, 1'b1, 11'h006, 32'h0, 4'd7, 32'h11C23344, 0);
    applyStimulus("misaligned", 1'b0, 1'b0, 11'h002, 32'hCAFEF00D, 4'd1, 32'h0, 0);
    applyStimulus("timeout",    1'b1, 1'b0, 11'h040, 32'h0, 4'd2, 32'h55AA55AA, 20);
    applyStimulus("last_chance", 1'b0, 1'b0, 11'h044, 32'h01020304, 4'd2, 32'h0, TIMEOUT - 1);
    applyStimulus("pc_load",    1'b1, 1'b0, 11'h100, 32'h0, 4'd15, 32'h87654321, 1);
    applyStimulus("word_store", 1'b0, 1'b0, 11'h7FC, 32'hA5A5_0F0F, 4'd0, 32'h0, 0);

    // Reset while waiting for the RAM.
    start = 1'b1; is_load = 1'b1; is_byte = 1'b0;
    addr = 11'h020; rd_addr = 4'd5; mem_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid:pre_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    lastWData = '0;
    lastWAddr = '0;
    checkIdle("rst_mid");
    checkOutput("rst_mid:mem_addr", 32'(mem_addr), 32'd0);
    applyStimulus("after_rst", 1'b1, 1'b0, 11'h024, 32'h0, 4'd9, 32'h0BADC0DE, 1);

    for (int n = 0; n < 40; n++) begin
      ra   = ADDR_W'($urandom);
      rb   = 1'($urandom);
      if (!rb && ($urandom_range(0, 3) != 0)) ra[1:0] = 2'b00;
      rdly = ($urandom_range(0, 9) == 0) ? TIMEOUT + 1 : int'($urandom_range(0, 4));
      applyStimulus($sformatf("rand%0d", n), 1'($urandom), rb, ra, $urandom,
                    4'($urandom), $urandom, rdly);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
